// File: rtl/png_chunk_wr_if.sv
// Handshake and data bundle between the PNG chunk writer, its upstream source,
// the crc32 stage and the downstream byte-stream writer.
interface png_chunk_wr_if;
    logic        start_i;
    logic [31:0] len_i;
    logic [31:0] type_i;
    logic        val_i;
    logic [31:0] dat_i;
    logic        rdy_o;
    logic        crc_start_o;
    logic        crc_val_o;
    logic [31:0] crc_dat_o;
    logic [31:0] crc_dat_i;
    logic        val_o;
    logic [31:0] dat_o;
    logic        lst_o;
    logic        done_o;
    logic        busy_o;

    modport slave (
        input  start_i, len_i, type_i, val_i, dat_i, crc_dat_i,
        output rdy_o, crc_start_o, crc_val_o, crc_dat_o,
               val_o, dat_o, lst_o, done_o, busy_o
    );

    modport master (
        output start_i, len_i, type_i, val_i, dat_i, crc_dat_i,
        input  rdy_o, crc_start_o, crc_val_o, crc_dat_o,
               val_o, dat_o, lst_o, done_o, busy_o
    );
endinterface

// File: rtl/png_chunk_wr.sv
// Emits one PNG chunk (LENGTH, TYPE, DATA..., CRC) as 32-bit words, pacing the
// CRC-covered words into a byte-serial crc32 stage and appending its result.
module png_chunk_wr #(
    parameter int CNT_WD  = 16,
    parameter int CRC_CYC = 4
) (
    input  logic            clk,
    input  logic            rstn,
    png_chunk_wr_if.slave   bus
);

    localparam int PH_WD = $clog2(CRC_CYC);
    localparam logic [PH_WD-1:0] PH_LAST = PH_WD'(CRC_CYC - 1);
    localparam logic [PH_WD-1:0] PH_RDY  = PH_WD'(CRC_CYC - 2);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        TYPE,
        DATA,
        WAIT,
        CRC
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_WD-1:0]   cnt_q, cnt_d;
    logic [31:0]         type_q, type_d;
    logic [PH_WD-1:0]    ph_q, ph_d;
    logic                rdy_q, rdy_d;
    logic                crcStart_q, crcStart_d;
    logic                crcVal_q, crcVal_d;
    logic [31:0]         crcDat_q, crcDat_d;
    logic                val_q, val_d;
    logic [31:0]         dat_q, dat_d;
    logic                lst_q, lst_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                accept;

    assign accept = rdy_q && bus.val_i && (state_q == DATA);

    // ph_q counts cycles since the last crc32 feed pulse and saturates at the
    // last byte slot; it gates both the next feed slot and the CRC readback.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        type_d     = type_q;
        ph_d       = (ph_q == PH_LAST) ? ph_q : ph_q + PH_WD'(1);
        rdy_d      = 1'b0;
        crcStart_d = 1'b0;
        crcVal_d   = 1'b0;
        crcDat_d   = (ph_q == PH_LAST) ? 32'h0 : crcDat_q;
        val_d      = 1'b0;
        dat_d      = 32'h0;
        lst_d      = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                crcDat_d = 32'h0;
                if (bus.start_i) begin
                    type_d     = bus.type_i;
                    cnt_d      = bus.len_i[CNT_WD+1:2];
                    val_d      = 1'b1;
                    dat_d      = bus.len_i & 32'hFFFF_FFFC;
                    crcStart_d = 1'b1;
                    state_d    = LEN;
                end
            end
            LEN: begin
                val_d    = 1'b1;
                dat_d    = type_q;
                crcVal_d = 1'b1;
                crcDat_d = type_q;
                ph_d     = '0;
                state_d  = TYPE;
            end
            TYPE: begin
                state_d = (cnt_q == '0) ? WAIT : DATA;
            end
            DATA: begin
                if (accept) begin
                    val_d    = 1'b1;
                    dat_d    = bus.dat_i;
                    crcVal_d = 1'b1;
                    crcDat_d = bus.dat_i;
                    ph_d     = '0;
                    cnt_d    = cnt_q - CNT_WD'(1);
                    if (cnt_q == CNT_WD'(1)) begin
                        state_d = WAIT;
                    end
                end else begin
                    rdy_d = (ph_q >= PH_RDY);
                end
            end
            WAIT: begin
                if (ph_q == PH_LAST) begin
                    state_d = CRC;
                end
            end
            CRC: begin
                val_d   = 1'b1;
                dat_d   = bus.crc_dat_i;
                lst_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // A reset mid-chunk simply drops the chunk; no CRC word is produced.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            type_q     <= 32'h0;
            ph_q       <= '0;
            rdy_q      <= 1'b0;
            crcStart_q <= 1'b0;
            crcVal_q   <= 1'b0;
            crcDat_q   <= 32'h0;
            val_q      <= 1'b0;
            dat_q      <= 32'h0;
            lst_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            ph_q       <= ph_d;
            rdy_q      <= rdy_d;
            crcStart_q <= crcStart_d;
            crcVal_q   <= crcVal_d;
            crcDat_q   <= crcDat_d;
            val_q      <= val_d;
            dat_q      <= dat_d;
            lst_q      <= lst_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rdy_o       = rdy_q;
    assign bus.crc_start_o = crcStart_q;
    assign bus.crc_val_o   = crcVal_q;
    assign bus.crc_dat_o   = crcDat_q;
    assign bus.val_o       = val_q;
    assign bus.dat_o       = dat_q;
    assign bus.lst_o       = lst_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = busy_q;

    // The word counter only holds len_i[CNT_WD+1:2]; wider lengths would wrap.
    lenRange: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == IDLE && bus.start_i) |-> (bus.len_i[31:CNT_WD+2] == '0));

endmodule

// File: tb/tb_png_chunk_wr.sv
// Scoreboard bench for png_chunk_wr with a behavioural byte-serial crc32 stage
// that only presents its finalised CRC four cycles after the last feed.
module tb_png_chunk_wr;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    png_chunk_wr_if bus();

    png_chunk_wr #(.CNT_WD(16), .CRC_CYC(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] dat;
        logic        lst;
        int          cyc;
    } expWord_t;

    expWord_t    expQ[$];
    expWord_t    feedQ[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] words [0:3];
    logic [31:0] stubCrc = 32'hFFFF_FFFF;
    int          stubDelay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] crcUpd(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 3; b >= 0; b--) begin
            r = r ^ {24'h0, w[8*b +: 8]};
            for (int i = 0; i < 8; i++) begin
                r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] refCrc(input logic [31:0] typ, input int n);
        logic [31:0] r;
        r = crcUpd(32'hFFFF_FFFF, typ);
        for (int i = 0; i < n; i++) r = crcUpd(r, words[i]);
        return ~r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // crc32 stand-in: the result is withheld until four cycles after the last feed.
    always @(negedge clk) begin
        if (!rstn) begin
            stubDelay     = 0;
            bus.crc_dat_i = 32'hDEAD_BEEF;
        end else begin
            if (bus.crc_start_o) begin
                stubCrc       = 32'hFFFF_FFFF;
                stubDelay     = 0;
                bus.crc_dat_i = 32'hDEAD_BEEF;
            end
            if (bus.crc_val_o) begin
                stubCrc       = crcUpd(stubCrc, bus.crc_dat_o);
                stubDelay     = 4;
                bus.crc_dat_i = 32'hDEAD_BEEF;
            end else if (stubDelay > 0) begin
                stubDelay--;
                if (stubDelay == 0) bus.crc_dat_i = ~stubCrc;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a word or a feed.
    always @(negedge clk) begin
        expWord_t e;
        if (rstn) begin
            if (bus.val_o) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedWord at cycle %0d: got %h expected none", cyc, bus.dat_o);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outDat", bus.dat_o, e.dat);
                    checkOutput("outCyc", cyc, e.cyc);
                    checkOutput("outLstDone", {bus.lst_o, bus.done_o}, {e.lst, e.lst});
                end
            end else if (bus.lst_o || bus.done_o) begin
                checkOutput("strayLstDone", {bus.lst_o, bus.done_o}, 32'h0);
            end
            if (bus.crc_val_o) begin
                if (feedQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedFeed at cycle %0d: got %h expected none", cyc, bus.crc_dat_o);
                end else begin
                    e = feedQ.pop_front();
                    checkOutput("feedDat", bus.crc_dat_o, e.dat);
                    checkOutput("feedCyc", cyc, e.cyc);
                end
            end
        end
    end

    task automatic checkAllZero(input string name);
        checkOutput({name, "Dat"}, bus.dat_o, 32'h0);
        checkOutput({name, "CrcDat"}, bus.crc_dat_o, 32'h0);
        checkOutput({name, "Ctl"}, {bus.val_o, bus.lst_o, bus.done_o, bus.busy_o,
                                    bus.rdy_o, bus.crc_start_o, bus.crc_val_o}, 32'h0);
    endtask

    // Runs one chunk; the bench decides acceptance from its own slot model.
    task automatic applyStimulus(input logic [31:0] len, input logic [31:0] typ, input int firstVal,
                                 input logic [31:0] expCrc, input int startA, input int startB,
                                 input int valPulse, input int abortRel);
        int c0, t, n, idx, slot, lastF, crcCyc;
        logic [31:0] lastV;
        logic expRdy;
        c0     = cyc;
        n      = int'(len[31:2]);
        idx    = 0;
        slot   = c0 + 5;
        lastF  = c0 + 2;
        lastV  = typ;
        crcCyc = -1;
        expQ.push_back('{dat: len & 32'hFFFF_FFFC, lst: 1'b0, cyc: c0 + 1});
        expQ.push_back('{dat: typ, lst: 1'b0, cyc: c0 + 2});
        feedQ.push_back('{dat: typ, lst: 1'b0, cyc: c0 + 2});
        if (n == 0) begin
            crcCyc = c0 + 7;
            expQ.push_back('{dat: expCrc, lst: 1'b1, cyc: crcCyc});
        end
        forever begin
            t = cyc;
            if (t == crcCyc) break;
            if (t >= c0 + 200) begin
                checkOutput("chunkTimeout", 32'd1, 32'd0);
                break;
            end
            if (abortRel >= 0 && t == c0 + abortRel) begin
                rstn = 1'b0;
                #1;
                checkAllZero("abort");
                bus.start_i = 1'b0;
                bus.val_i   = 1'b0;
                repeat (2) @(posedge clk);
                #1 rstn = 1'b1;
                return;
            end
            bus.start_i = (t == c0) || (t == c0 + startA) || (t == c0 + startB);
            bus.len_i   = (t == c0) ? len : 32'h0000_0040;
            bus.type_i  = (t == c0) ? typ : 32'h1111_1111;
            if (idx < n && t >= c0 + firstVal) begin
                bus.val_i = 1'b1;
                bus.dat_i = words[idx];
            end else if (t == c0 + valPulse) begin
                bus.val_i = 1'b1;
                bus.dat_i = 32'hBAD0_BAD0;
            end else begin
                bus.val_i = 1'b0;
                bus.dat_i = 32'h0;
            end
            @(negedge clk);
            expRdy = (idx < n) && (t >= slot);
            checkOutput("rdy", bus.rdy_o, expRdy);
            checkOutput("busy", bus.busy_o, t > c0);
            checkOutput("crcStart", bus.crc_start_o, t == c0 + 1);
            checkOutput("crcHold", bus.crc_dat_o, (t >= lastF && t <= lastF + 3) ? lastV : 32'h0);
            if (bus.val_i && expRdy) begin
                expQ.push_back('{dat: words[idx], lst: 1'b0, cyc: t + 1});
                feedQ.push_back('{dat: words[idx], lst: 1'b0, cyc: t + 1});
                lastF = t + 1;
                lastV = words[idx];
                idx++;
                slot = t + 4;
                if (idx == n) begin
                    crcCyc = t + 6;
                    expQ.push_back('{dat: expCrc, lst: 1'b1, cyc: crcCyc});
                end
            end
            @(posedge clk);
            #1;
        end
        bus.start_i = 1'b0;
        bus.val_i   = 1'b0;
        bus.dat_i   = 32'h0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput("idleBusy", bus.busy_o, 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start_i = 1'b0;
        bus.len_i   = 32'h0;
        bus.type_i  = 32'h0;
        bus.val_i   = 1'b0;
        bus.dat_i   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1 rstn = 1'b1;
        idleCycles(1);

        // IEND: empty chunk, CRC seven cycles after start.
        applyStimulus(32'd0, 32'h4945_4E44, 0, 32'hAE42_6082, -1, -1, -1, -1);
        idleCycles(2);

        // gAMA with the word ready at the first slot.
        words[0] = 32'h0000_B18F;
        applyStimulus(32'd4, 32'h6741_4D41, 5, 32'h0BFC_6105, -1, -1, -1, -1);
        idleCycles(1);

        // gAMA with a long upstream gap.
        applyStimulus(32'd4, 32'h6741_4D41, 20, 32'h0BFC_6105, -1, -1, -1, -1);
        idleCycles(1);

        // tEXt streaming three words, then IEND on the done cycle.
        words[0] = 32'h4B65_7900;
        words[1] = 32'h5661_6C31;
        words[2] = 32'h4162_6364;
        applyStimulus(32'd12, 32'h7445_5874, 1, refCrc(32'h7445_5874, 3), -1, -1, -1, -1);
        applyStimulus(32'd0, 32'h4945_4E44, 0, 32'hAE42_6082, -1, -1, -1, -1);
        idleCycles(1);

        // gAMA with stray start pulses and an unready val_i pulse.
        words[0] = 32'h0000_B18F;
        applyStimulus(32'd4, 32'h6741_4D41, 5, 32'h0BFC_6105, 3, 6, 7, -1);
        idleCycles(1);

        // Reset in the middle of an 8-byte chunk, then a clean IEND.
        words[0] = 32'h0102_0304;
        words[1] = 32'h0506_0708;
        applyStimulus(32'd8, 32'h7465_5354, 5, 32'h0, -1, -1, -1, 7);
        idleCycles(2);
        applyStimulus(32'd0, 32'h4945_4E44, 0, 32'hAE42_6082, -1, -1, -1, -1);
        idleCycles(2);

        checkOutput("expQEmpty", expQ.size(), 32'h0);
        checkOutput("feedQEmpty", feedQ.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/png_chunk_wr.md
Name: png_chunk_wr

Overview:
- Assembles one PNG chunk as a stream of 32-bit big-endian words: LENGTH, TYPE, DATA words, CRC.
- Sits directly upstream of the crc32 stage. It paces TYPE and DATA words into crc32 at one word per 4 cycles, which matches crc32's byte-serial rate.
- It reads back the finished CRC from crc32 and appends it as the final word.
- Downstream is the PNG byte-stream writer. That interface has no backpressure.

Parameters:
- CNT_WD, 16: width of the remaining-data-word counter. len_i[31:CNT_WD+2] must be zero.
- CRC_CYC, 4: cycles crc32 needs per 32-bit word. Fixed by the crc32 byte width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- start_i  in  1  chunk start pulse; sampled only in IDLE
- len_i  in  32  chunk data length in bytes; sampled with start_i
- type_i  in  32  chunk type, big-endian ASCII; sampled with start_i
- val_i  in  1  upstream data word valid
- dat_i  in  32  upstream data word, big-endian
- rdy_o  out  1  block can accept dat_i this cycle
- crc_start_o  out  1  re-initialise crc32 to 0xFFFFFFFF
- crc_val_o  out  1  crc32 word strobe; one-cycle pulse
- crc_dat_o  out  32  crc32 word; held 4 cycles from crc_val_o
- crc_dat_i  in  32  finalised CRC from crc32
- val_o  out  1  output word valid
- dat_o  out  32  output word
- lst_o  out  1  marks the CRC word
- done_o  out  1  chunk complete; coincident with lst_o
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. Every output resets to 0 and state resets to IDLE. Reset mid-chunk abandons the chunk with no CRC word, and the next start_i behaves normally.
- All outputs are registered.
- Word count = len_i[31:2]. The emitted LENGTH word is {len_i[31:2],2'b00}; low bits are forced to 0.
- Cycle 0 is the cycle start_i is accepted in IDLE.
- FSM states: IDLE, LEN, TYPE, DATA, WAIT, CRC.
- IDLE: on start_i, latch len/type and load the counter.
- LEN (cycle 1):
  - val_o=1, dat_o=LENGTH word.
  - crc_start_o=1.
  - LENGTH is excluded from the CRC.
- TYPE (cycle 2):
  - val_o=1, dat_o=type.
  - crc_val_o=1; crc_dat_o=type, held cycles 2-5.
- DATA, count>0:
  - rdy_o=1 from cycle 5, and again 4 cycles after each previous feed pulse minus 1. The feed slot is therefore always 4 cycles apart.
  - A word is accepted when val_i&&rdy_o at cycle k.
  - At k+1: val_o=1 and dat_o=word; crc_val_o=1 and crc_dat_o=word, held k+1..k+4.
  - rdy_o stays low k+1..k+3 and the counter decrements.
  - Upstream gaps are unbounded. rdy_o stays high while a slot is free, and no output is produced during the gap.
- Last feed: let f be the cycle of the last crc_val_o pulse (f=2 when count=0).
  - WAIT covers up to f+3.
  - At f+4, crc_dat_i is valid and is sampled.
  - At f+5: val_o=1, dat_o=CRC, lst_o=1, done_o=1. Return to IDLE.
- Latency: zero-length chunk, start to CRC word = 7 cycles. Otherwise the CRC word appears at k_last+6.
- Ignored inputs:
  - start_i while busy_o=1 is ignored.
  - val_i while rdy_o=0 is ignored and the word is not consumed.
  - val_i in IDLE/LEN/TYPE/WAIT/CRC is ignored.
- Back-to-back chunks: start_i is accepted on the cycle done_o is high; the FSM is back in IDLE that cycle. crc_start_o then re-initialises crc32 before its TYPE feed.
- crc_dat_o is 0 when not feeding. crc_val_o is never high on two cycles less than 4 apart.

Test Plan:
- IEND: start_i len=0, type=0x49454E44 -> expect:
  - dat_o 0x00000000 @1
  - 0x49454E44 @2 with crc_val_o
  - 0xAE426082 @7 with lst_o=done_o=1
  - busy_o low @8
- gAMA: len=4, type=0x67414D41, val_i dat_i=0x0000B18F held from cycle 5 -> expect:
  - accepted @5
  - dat_o 0x00000004 @1, 0x67414D41 @2, 0x0000B18F @6
  - CRC 0x0BFC6105 @11 with lst_o
- Upstream gap: same gAMA, but val_i first raised @20 -> rdy_o high 5..20, no val_o 3..20, word @21, CRC 0x0BFC6105 @26.
- Streaming and back-to-back: len=12, val_i held high -> expect:
  - accepts @5,9,13; rdy_o low 6-8 and 10-12
  - CRC word @19
  - IEND start_i @19 (on done_o) -> CRC 0xAE426082 @26, proving re-init.
- Protocol abuse: start_i pulses @3 and @6 during a gAMA chunk, and val_i pulses @7 (rdy_o=0) -> expect:
  - both start_i pulses ignored
  - @7 word not consumed
  - output sequence and CRC identical to the gAMA scenario
- Reset mid-DATA: rstn low @7 during an 8-byte chunk -> all outputs 0 immediately, state IDLE; a subsequent IEND gives 0xAE426082.
